// File: rtl/data_mem_responder.sv
// Word-addressed data memory behind valid/ready request and response channels.
// A fixed LATENCY separates request acceptance from the response. Bad addresses are flagged.
module data_mem_responder #(
    parameter int unsigned MEM_DEPTH = 1024,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] txn_count
);

    localparam int unsigned AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [31:0] DEPTH_W   = 32'(MEM_DEPTH);
    localparam logic [3:0]  WAIT_INIT = 4'(LATENCY - 1);
    localparam bit          SKIP_WAIT = (LATENCY <= 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        lat_we_q;
    logic [31:0] lat_addr_q;
    logic [31:0] lat_wdata_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;
    logic [31:0] txn_count_q;

    logic [31:0] mem [MEM_DEPTH];

    logic          commit;
    logic          c_we;
    logic          c_err;
    logic [31:0]   c_addr;
    logic [31:0]   c_wdata;
    logic [AW-1:0] c_idx;

    // With LATENCY == 1 the commit happens on the accept edge, straight from the request inputs.
    always_comb begin
        commit  = 1'b0;
        c_we    = lat_we_q;
        c_addr  = lat_addr_q;
        c_wdata = lat_wdata_q;
        if (state_q == StIdle) begin
            commit  = SKIP_WAIT && req_valid;
            c_we    = req_we;
            c_addr  = req_addr;
            c_wdata = req_wdata;
        end else if (state_q == StWait) begin
            commit = (cnt_q == 4'd1);
        end
        c_err = (c_addr[1:0] != 2'b00) || ({2'b00, c_addr[31:2]} >= DEPTH_W);
        c_idx = c_addr[AW+1:2];
    end

    always_ff @(posedge clk) begin
        if (commit && c_we && !c_err) begin
            mem[c_idx] <= c_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            lat_we_q     <= 1'b0;
            lat_addr_q   <= 32'd0;
            lat_wdata_q  <= 32'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
            txn_count_q  <= 32'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        lat_we_q    <= req_we;
                        lat_addr_q  <= req_addr;
                        lat_wdata_q <= req_wdata;
                        req_ready_q <= 1'b0;
                        if (SKIP_WAIT) begin
                            state_q      <= StResp;
                            resp_valid_q <= 1'b1;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= WAIT_INIT;
                        end
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q      <= StResp;
                        resp_valid_q <= 1'b1;
                    end
                end
                StResp: begin
                    if (resp_ready) begin
                        state_q      <= StIdle;
                        req_ready_q  <= 1'b1;
                        resp_valid_q <= 1'b0;
                        txn_count_q  <= txn_count_q + 32'd1;
                    end
                end
                default: begin
                    state_q      <= StIdle;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                end
            endcase
            if (commit) begin
                resp_err_q   <= c_err;
                resp_rdata_q <= (!c_we && !c_err) ? mem[c_idx] : 32'd0;
            end
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign txn_count  = txn_count_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LATENCY 1, 2, 4) checked against a
// word-addressed memory model with transaction counting.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst        [3];
    logic        req_valid  [3];
    logic        req_we     [3];
    logic [31:0] req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic        req_ready  [3];
    logic        resp_valid [3];
    logic        resp_ready [3];
    logic [31:0] resp_rdata [3];
    logic        resp_err   [3];
    logic [31:0] txn_count  [3];

    int          lat [3] = '{1, 2, 4};
    int          exp_cnt [3] = '{0, 0, 0};
    logic [31:0] mdl [longint];
    int          n_chk = 0;
    int          n_bad = 0;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.MEM_DEPTH(1024), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
        .resp_err(resp_err[0]), .txn_count(txn_count[0])
    );
    data_mem_responder #(.MEM_DEPTH(1024), .LATENCY(2)) u_dut_l2 (
        .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
        .resp_err(resp_err[1]), .txn_count(txn_count[1])
    );
    data_mem_responder #(.MEM_DEPTH(1024), .LATENCY(4)) u_dut_l4 (
        .clk(clk), .reset(rst[2]), .req_valid(req_valid[2]), .req_we(req_we[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_ready(req_ready[2]),
        .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]), .resp_rdata(resp_rdata[2]),
        .resp_err(resp_err[2]), .txn_count(txn_count[2])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit bad_addr(input logic [31:0] a);
        return (a % 4 != 0) || (a / 4 >= 1024);
    endfunction

    function automatic longint key_of(input int d, input logic [31:0] a);
        return (longint'(d) << 32) | longint'(a / 4);
    endfunction

    // Call at #1 after an edge; returns at #1 after the accepting edge.
    task automatic issue(input int d, input bit we, input logic [31:0] a, input logic [31:0] wd);
        int n = 0;
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        while (!req_ready[d] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("accept_ready", {31'd0, req_ready[d]}, 32'd1);
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        req_we[d]    = 1'($urandom);
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
    endtask

    task automatic run_txn(input int d, input bit we, input logic [31:0] a,
                           input logic [31:0] wd, input int hold);
        int          k = 0;
        bit          e_err;
        bit          known;
        logic [31:0] e_data;
        longint      key;
        e_err = bad_addr(a);
        key   = key_of(d, a);
        issue(d, we, a, wd);
        check_eq("busy_ready", {31'd0, req_ready[d]}, 32'd0);
        while (!resp_valid[d] && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq("latency", k, lat[d] - 1);
        if (!e_err && we) mdl[key] = wd;
        known  = e_err || we || mdl.exists(key);
        e_data = (e_err || we || !mdl.exists(key)) ? 32'd0 : mdl[key];
        check_eq("resp_err", {31'd0, resp_err[d]}, {31'd0, e_err});
        if (known) check_eq("resp_rdata", resp_rdata[d], e_data);
        for (int i = 0; i < hold; i++) begin
            req_valid[d] = 1'($urandom);
            req_addr[d]  = 32'($urandom_range(0, 15)) << 2;
            @(posedge clk); #1;
            check_eq("hold_valid", {31'd0, resp_valid[d]}, 32'd1);
            check_eq("hold_ready", {31'd0, req_ready[d]}, 32'd0);
            if (known) check_eq("hold_rdata", resp_rdata[d], e_data);
        end
        // A pending request during the consume edge must not be accepted on that edge.
        req_valid[d]  = (hold > 0);
        req_we[d]     = 1'b0;
        resp_ready[d] = 1'b1;
        @(posedge clk); #1;
        resp_ready[d] = 1'b0;
        req_valid[d]  = 1'b0;
        exp_cnt[d]++;
        check_eq("done_valid", {31'd0, resp_valid[d]}, 32'd0);
        check_eq("done_ready", {31'd0, req_ready[d]}, 32'd1);
        check_eq("txn_count", txn_count[d], exp_cnt[d]);
    endtask

    task automatic check_reset_vals(input int d);
        check_eq("rst_req_ready", {31'd0, req_ready[d]}, 32'd1);
        check_eq("rst_resp_valid", {31'd0, resp_valid[d]}, 32'd0);
        check_eq("rst_txn_count", txn_count[d], 32'd0);
    endtask

    initial begin
        int          acc [3];
        logic [31:0] wv  [3];
        logic [31:0] a;
        int          r;
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'd0;
            req_wdata[d] = 32'd0; resp_ready[d] = 1'b0;
        end
        #3;
        for (int d = 0; d < 3; d++) begin
            check_reset_vals(d);
            check_eq("rst_rdata", resp_rdata[d], 32'd0);
            check_eq("rst_err", {31'd0, resp_err[d]}, 32'd0);
        end
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        @(posedge clk); #1;

        // Directed sequence on the LATENCY=2 instance.
        run_txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 0);
        run_txn(1, 1'b0, 32'h10, 32'h0, 0);
        run_txn(1, 1'b1, 32'h13, 32'h12345678, 0);
        run_txn(1, 1'b0, 32'h10, 32'h0, 0);
        run_txn(1, 1'b0, 32'h1000, 32'h0, 0);
        run_txn(1, 1'b0, 32'hFFC, 32'h0, 0);
        run_txn(1, 1'b0, 32'h10, 32'h0, 5);

        // Back-to-back stores with resp_ready held high on the LATENCY=1 instance.
        resp_ready[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            int n = 0;
            wv[i] = $urandom;
            req_valid[0] = 1'b1; req_we[0] = 1'b1;
            req_addr[0] = 32'(i * 4); req_wdata[0] = wv[i];
            while (!req_ready[0] && n < 10) begin
                @(posedge clk); #1;
                n++;
            end
            @(posedge clk); #1;
            acc[i] = cyc;
            mdl[key_of(0, 32'(i * 4))] = wv[i];
        end
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        resp_ready[0] = 1'b0;
        exp_cnt[0] += 3;
        check_eq("b2b_gap0", acc[1] - acc[0], 32'd2);
        check_eq("b2b_gap1", acc[2] - acc[1], 32'd2);
        check_eq("b2b_txn", txn_count[0], exp_cnt[0]);
        for (int i = 0; i < 3; i++) run_txn(0, 1'b0, 32'(i * 4), 32'h0, 0);

        // Reset while in RESP: the store has committed but the count clears.
        issue(0, 1'b1, 32'h40, 32'h55AA55AA);
        check_eq("resp_before_rst", {31'd0, resp_valid[0]}, 32'd1);
        rst[0] = 1'b1;
        #1;
        check_reset_vals(0);
        exp_cnt[0] = 0;
        mdl[key_of(0, 32'h40)] = 32'h55AA55AA;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        run_txn(0, 1'b0, 32'h40, 32'h0, 0);

        // Reset mid-WAIT on LATENCY=4: the store is dropped.
        run_txn(2, 1'b1, 32'h20, 32'h0, 0);
        issue(2, 1'b1, 32'h20, 32'hCAFEF00D);
        @(posedge clk); #1;
        rst[2] = 1'b1;
        #1;
        check_reset_vals(2);
        exp_cnt[2] = 0;
        @(posedge clk); #1;
        rst[2] = 1'b0;
        run_txn(2, 1'b0, 32'h20, 32'h0, 0);

        // Randomized traffic on every instance.
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 20; i++) begin
                r = int'($urandom_range(0, 9));
                if (r < 6)      a = 32'($urandom_range(0, 31)) << 2;
                else if (r < 7) a = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(1, 3));
                else if (r < 8) a = 32'h1000 + (32'($urandom_range(0, 255)) << 2);
                else if (r < 9) a = 32'hFFC;
                else            a = $urandom;
                run_txn(d, 1'($urandom), a, $urandom, int'($urandom_range(0, 3)));
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
